bp_me_cce_mem_responder: RTL and testbench

- Synthesizable memory-side endpoint for the CCE-MEM interface, using the BedRock Stream protocol with ready&valid handshakes.
- Consumes mem_cmd beats (header + dword data + last) issued by the CCE and returns mem_resp beats with the same signalling.
- Backs a small word-addressed storage array; used in ME unit benches and small SoC configs in place of a DRAM controller.

---
 rtl/bp_me_cce_mem_responder_pkg.sv | 51 +++++
 rtl/bp_me_cce_mem_responder_if.sv | 29 ++
 rtl/bp_me_cce_mem_responder_array.sv | 34 +++
 rtl/bp_me_cce_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_bp_me_cce_mem_responder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_me_cce_mem_responder_pkg.sv
// Shared types for the CCE-MEM responder: BedRock mem header layout,
// message type/size encodings, responder FSM states and beat-count helper.
package bp_me_pkg;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  localparam int paddr_width_lp   = 40;
  localparam int payload_width_lp = 16;

  // Size is the log2 of the byte count: 0..7 = 1..128 bytes.
  typedef struct packed {
    logic [payload_width_lp-1:0] payload;
    logic [2:0]                  size;
    logic [paddr_width_lp-1:0]   addr;
    logic [3:0]                  subop;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  localparam int cce_mem_msg_header_width_lp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic [1:0] {
    e_ready,
    e_write_data,
    e_write_resp,
    e_read_resp
  } bp_me_mem_resp_state_e;

  // Number of 64-bit beats in a message of the given size, capped at one block.
  function automatic int unsigned beat_count(input logic [2:0] size, input int unsigned max_beats);
    int unsigned n;
    n = (size < 3'd3) ? 32'd1 : (32'd1 << (size - 3'd3));
    if (n > max_beats) n = max_beats;
    return n;
  endfunction

  function automatic logic is_read(input bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_rd) || (t == e_bedrock_mem_uc_rd);
  endfunction

  function automatic logic is_write(input bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
  endfunction

endpackage

// File: rtl/bp_me_cce_mem_responder_if.sv
// BedRock stream CCE-MEM link: command channel from the CCE, response back.
interface bp_me_cce_mem_responder_if
  #(parameter int header_width_p = bp_me_pkg::cce_mem_msg_header_width_lp);

  logic [header_width_p-1:0] mem_cmd_header;
  logic [63:0]               mem_cmd_data;
  logic                      mem_cmd_v;
  logic                      mem_cmd_ready_and;
  logic                      mem_cmd_last;

  logic [header_width_p-1:0] mem_resp_header;
  logic [63:0]               mem_resp_data;
  logic                      mem_resp_v;
  logic                      mem_resp_ready_and;
  logic                      mem_resp_last;

  // CCE side
  modport master (
    output mem_cmd_header, mem_cmd_data, mem_cmd_v, mem_cmd_last, mem_resp_ready_and,
    input  mem_cmd_ready_and, mem_resp_header, mem_resp_data, mem_resp_v, mem_resp_last
  );

  // Memory side
  modport slave (
    input  mem_cmd_header, mem_cmd_data, mem_cmd_v, mem_cmd_last, mem_resp_ready_and,
    output mem_cmd_ready_and, mem_resp_header, mem_resp_data, mem_resp_v, mem_resp_last
  );

endinterface

// File: rtl/bp_me_cce_mem_responder_array.sv
// Single-port word RAM with byte write mask and registered read data.
// Contents and read register are intentionally not reset; data_o holds
// its value whenever no read is issued, which the responder relies on
// to keep a stalled response beat stable.
module bp_me_cce_mem_responder_array
  #(parameter int els_p = 1024
  , localparam int lg_els_lp = $clog2(els_p)
  )
  (input  logic                 clk_i
  , input  logic                 v_i
  , input  logic                 w_i
  , input  logic [lg_els_lp-1:0] addr_i
  , input  logic [63:0]          data_i
  , input  logic [7:0]           write_mask_i
  , output logic [63:0]          data_o
  );

  logic [63:0] mem_r [els_p];

  // Byte-masked write
  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int i = 0; i < 8; i++) begin
        if (write_mask_i[i]) mem_r[addr_i][8*i +: 8] <= data_i[8*i +: 8];
      end
    end
  end

  // Synchronous read, output held between reads
  always_ff @(posedge clk_i) begin
    if (v_i & ~w_i) data_o <= mem_r[addr_i];
  end

endmodule

// File: rtl/bp_me_cce_mem_responder.sv
// Memory-side endpoint for the CCE-MEM BedRock stream link, backed by a
// small word RAM. Bursts are critical-word-first, wrapping in the aligned
// N-word block; upper address bits alias.
//
//   state        | meaning
//   e_ready      | idle, accepting a command header beat
//   e_write_data | accepting remaining command beats (write data or drained extras)
//   e_write_resp | presenting the single ack beat
//   e_read_resp  | presenting read data beats, one RAM word per beat
module bp_me_cce_mem_responder
  import bp_me_pkg::*;
  #(parameter int mem_els_p         = 1024
  , parameter int cce_block_width_p = 512
  , parameter int header_width_p    = cce_mem_msg_header_width_lp
  )
  (input  logic clk_i
  , input  logic reset_i
  , bp_me_cce_mem_responder_if.slave mem_if
  );

  localparam int lg_els_lp    = $clog2(mem_els_p);
  localparam int max_beats_lp = cce_block_width_p / 64;
  localparam int cnt_width_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;

  bp_me_mem_resp_state_e    state_r;
  bp_bedrock_mem_header_s   hdr_r, cmd_hdr;
  logic [cnt_width_lp-1:0]  cnt_r, cnt_nxt, last_cnt;
  logic                     cmd_ready_r, resp_v_r, resp_last_r;
  logic                     cmd_yumi, resp_yumi;

  logic                     ram_v, ram_w;
  logic [lg_els_lp-1:0]     ram_addr;
  logic [63:0]              ram_wdata, ram_rdata;
  logic [7:0]               ram_mask;

  // Word index of burst beat k: wrap inside the aligned N-word block
  function automatic logic [lg_els_lp-1:0] word_index(input bp_bedrock_mem_header_s h,
                                                      input logic [cnt_width_lp-1:0] k);
    logic [lg_els_lp-1:0] base, nmask;
    base  = h.addr[3 +: lg_els_lp];
    nmask = lg_els_lp'(beat_count(h.size, max_beats_lp) - 32'd1);
    return (base & ~nmask) | ((base + lg_els_lp'(k)) & nmask);
  endfunction

  function automatic logic [7:0] byte_mask(input bp_bedrock_mem_header_s h);
    logic [7:0] m;
    case (h.size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    if (h.size < 3'd3) m = m << h.addr[2:0];
    return m;
  endfunction

  // Sub-word data arrives in the low bytes; steer it to its byte lanes
  function automatic logic [63:0] align_data(input bp_bedrock_mem_header_s h, input logic [63:0] d);
    return (h.size < 3'd3) ? (d << {h.addr[2:0], 3'b000}) : d;
  endfunction

  assign cmd_hdr   = mem_if.mem_cmd_header;
  assign cmd_yumi  = mem_if.mem_cmd_v & cmd_ready_r;
  assign resp_yumi = resp_v_r & mem_if.mem_resp_ready_and;
  assign cnt_nxt   = cnt_r + cnt_width_lp'(1);
  assign last_cnt  = cnt_width_lp'(beat_count(hdr_r.size, max_beats_lp) - 32'd1);

  assign mem_if.mem_cmd_ready_and = cmd_ready_r;
  assign mem_if.mem_resp_v        = resp_v_r;
  assign mem_if.mem_resp_last     = resp_last_r;
  assign mem_if.mem_resp_header   = hdr_r;
  assign mem_if.mem_resp_data     = (state_r == e_read_resp) ? ram_rdata : 64'd0;

  // RAM strobes: the next read beat is fetched on the handshake of the current one
  always_comb begin
    ram_v     = 1'b0;
    ram_w     = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_mask  = '0;
    unique case (state_r)
      e_ready: begin
        if (cmd_yumi) begin
          if (is_read(cmd_hdr.msg_type) && mem_if.mem_cmd_last) begin
            ram_v    = 1'b1;
            ram_addr = word_index(cmd_hdr, '0);
          end else if (is_write(cmd_hdr.msg_type)) begin
            ram_v     = 1'b1;
            ram_w     = 1'b1;
            ram_addr  = word_index(cmd_hdr, '0);
            ram_wdata = align_data(cmd_hdr, mem_if.mem_cmd_data);
            ram_mask  = byte_mask(cmd_hdr);
          end
        end
      end
      e_write_data: begin
        if (cmd_yumi) begin
          if (is_write(hdr_r.msg_type)) begin
            ram_v     = 1'b1;
            ram_w     = 1'b1;
            ram_addr  = word_index(hdr_r, cnt_r);
            ram_wdata = align_data(hdr_r, mem_if.mem_cmd_data);
            ram_mask  = byte_mask(hdr_r);
          end else if (is_read(hdr_r.msg_type) && mem_if.mem_cmd_last) begin
            ram_v    = 1'b1;
            ram_addr = word_index(hdr_r, '0);
          end
        end
      end
      e_read_resp: begin
        if (resp_yumi && !resp_last_r) begin
          ram_v    = 1'b1;
          ram_addr = word_index(hdr_r, cnt_nxt);
        end
      end
      default: ;
    endcase
  end

  // Responder FSM with registered handshake outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r     <= e_ready;
      hdr_r       <= '0;
      cnt_r       <= '0;
      cmd_ready_r <= 1'b0;
      resp_v_r    <= 1'b0;
      resp_last_r <= 1'b0;
    end else begin
      unique case (state_r)
        e_ready: begin
          cmd_ready_r <= 1'b1;
          if (cmd_yumi) begin
            hdr_r <= cmd_hdr;
            if (is_read(cmd_hdr.msg_type)) begin
              cnt_r <= '0;
              if (mem_if.mem_cmd_last) begin
                state_r     <= e_read_resp;
                cmd_ready_r <= 1'b0;
                resp_v_r    <= 1'b1;
                resp_last_r <= (beat_count(cmd_hdr.size, max_beats_lp) == 32'd1);
              end else begin
                state_r <= e_write_data;
              end
            end else begin
              // pre/amo take the write path with no RAM update
              cnt_r <= cnt_width_lp'(1);
              if (mem_if.mem_cmd_last) begin
                state_r     <= e_write_resp;
                cmd_ready_r <= 1'b0;
                resp_v_r    <= 1'b1;
                resp_last_r <= 1'b1;
              end else begin
                state_r <= e_write_data;
              end
            end
          end
        end
        e_write_data: begin
          if (cmd_yumi) begin
            cnt_r <= cnt_nxt;
            if (mem_if.mem_cmd_last) begin
              cmd_ready_r <= 1'b0;
              resp_v_r    <= 1'b1;
              if (is_read(hdr_r.msg_type)) begin
                state_r     <= e_read_resp;
                cnt_r       <= '0;
                resp_last_r <= (last_cnt == '0);
              end else begin
                state_r     <= e_write_resp;
                resp_last_r <= 1'b1;
              end
            end
          end
        end
        e_write_resp: begin
          if (resp_yumi) begin
            state_r     <= e_ready;
            resp_v_r    <= 1'b0;
            resp_last_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        e_read_resp: begin
          if (resp_yumi) begin
            if (resp_last_r) begin
              state_r     <= e_ready;
              resp_v_r    <= 1'b0;
              resp_last_r <= 1'b0;
              cmd_ready_r <= 1'b1;
            end else begin
              cnt_r       <= cnt_nxt;
              resp_last_r <= (cnt_nxt == last_cnt);
            end
          end
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  bp_me_cce_mem_responder_array #(.els_p(mem_els_p)) array (
    .clk_i        (clk_i),
    .v_i          (ram_v),
    .w_i          (ram_w),
    .addr_i       (ram_addr),
    .data_i       (ram_wdata),
    .write_mask_i (ram_mask),
    .data_o       (ram_rdata)
  );

endmodule

// File: tb/tb_bp_me_cce_mem_responder.sv
// Bench for the CCE-MEM responder: directed cases plus randomized traffic
// checked against a word-array reference memory.
module tb_bp_me_cce_mem_responder;
  import bp_me_pkg::*;

  localparam int mem_els_lp = 1024;

  logic clk = 1'b0;
  logic reset_i;

  always #5 clk = ~clk;

  bp_me_cce_mem_responder_if mem_if();

  bp_me_cce_mem_responder #(
    .mem_els_p         (mem_els_lp),
    .cce_block_width_p (512),
    .header_width_p    (cce_mem_msg_header_width_lp)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .mem_if  (mem_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] model_mem [mem_els_lp];
  logic [63:0] beat_data [8];
  logic [63:0] exp_data  [8];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_beats(input logic [2:0] size);
    int n;
    if (size < 3'd3) return 1;
    n = 1 << (int'(size) - 3);
    return (n > 8) ? 8 : n;
  endfunction

  function automatic int ref_idx(input logic [39:0] addr, input logic [2:0] size, input int k);
    int base, n;
    base = int'((addr >> 3) % mem_els_lp);
    n    = ref_beats(size);
    return (base / n) * n + ((base + k) % n);
  endfunction

  function automatic bp_bedrock_mem_header_s make_hdr(input bp_bedrock_mem_type_e t,
                                                      input logic [39:0] a, input logic [2:0] s);
    bp_bedrock_mem_header_s h;
    h          = '0;
    h.msg_type = t;
    h.addr     = a;
    h.size     = s;
    h.payload  = 16'($urandom());
    return h;
  endfunction

  task automatic model_write(input bp_bedrock_mem_header_s h, input int n);
    int idx, off, nb;
    for (int k = 0; k < n; k++) begin
      idx = ref_idx(h.addr, h.size, k);
      if (h.size < 3'd3) begin
        off = int'(h.addr[2:0]);
        nb  = 1 << int'(h.size);
        for (int b = off; b < off + nb && b < 8; b++)
          model_mem[idx][8*b +: 8] = beat_data[k][8*(b-off) +: 8];
      end else begin
        model_mem[idx] = beat_data[k];
      end
    end
  endtask

  task automatic send_cmd(input bp_bedrock_mem_header_s h, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      mem_if.mem_cmd_header = h;
      mem_if.mem_cmd_data   = beat_data[i];
      mem_if.mem_cmd_last   = (i == n - 1);
      mem_if.mem_cmd_v      = 1'b1;
      w = 0;
      while (!mem_if.mem_cmd_ready_and && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("cmd_ready", 128'(mem_if.mem_cmd_ready_and), 128'(1));
      @(negedge clk);
    end
    mem_if.mem_cmd_v    = 1'b0;
    mem_if.mem_cmd_last = 1'b0;
  endtask

  task automatic recv_resp(input bp_bedrock_mem_header_s h, input int n, input int stall_beat,
                           input int stall_cycles, input bit rand_stall, input int abort_after);
    int k, stalled, cyc;
    bit hold;
    k = 0; stalled = 0; cyc = 0;
    while (k < n && cyc < 400) begin
      if (mem_if.mem_resp_v) begin
        check("resp_hdr",  128'(mem_if.mem_resp_header), 128'(h));
        check("resp_data", 128'(mem_if.mem_resp_data),   128'(exp_data[k]));
        check("resp_last", 128'(mem_if.mem_resp_last),   128'(k == n - 1));
        check("cmd_rdy_in_resp", 128'(mem_if.mem_cmd_ready_and), 128'(0));
        hold = rand_stall && ($urandom_range(0, 3) == 0);
        if (k == stall_beat && stalled < stall_cycles) begin
          hold = 1'b1;
          stalled++;
        end
        mem_if.mem_resp_ready_and = !hold;
        if (!hold) k++;
      end else begin
        mem_if.mem_resp_ready_and = 1'b0;
      end
      if (k == abort_after) return;
      @(negedge clk);
      cyc++;
    end
    check("resp_beats", 128'(k), 128'(n));
    @(negedge clk);
    check("resp_idle_v",   128'(mem_if.mem_resp_v),        128'(0));
    check("cmd_rdy_after", 128'(mem_if.mem_cmd_ready_and), 128'(1));
    mem_if.mem_resp_ready_and = 1'b0;
  endtask

  task automatic do_write(input bp_bedrock_mem_header_s h, input int n, input bit rs);
    send_cmd(h, n);
    check("ack_latency", 128'(mem_if.mem_resp_v), 128'(1));
    if (is_write(h.msg_type)) model_write(h, n);
    exp_data[0] = '0;
    recv_resp(h, 1, -1, 0, rs, -1);
  endtask

  task automatic do_read(input bp_bedrock_mem_header_s h, input bit use_model, input int sb,
                         input int sc, input bit rs, input int abort_after);
    int n;
    n = ref_beats(h.size);
    if (use_model)
      for (int k = 0; k < n; k++) exp_data[k] = model_mem[ref_idx(h.addr, h.size, k)];
    beat_data[0] = '0;
    send_cmd(h, 1);
    check("rd_latency", 128'(mem_if.mem_resp_v), 128'(1));
    recv_resp(h, n, sb, sc, rs, abort_after);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    bp_bedrock_mem_header_s h;

    reset_i                   = 1'b0;
    mem_if.mem_cmd_header     = make_hdr(e_bedrock_mem_wr, 40'h80, 3'd6);
    mem_if.mem_cmd_data       = 64'h1234;
    mem_if.mem_cmd_v          = 1'b1;
    mem_if.mem_cmd_last       = 1'b1;
    mem_if.mem_resp_ready_and = 1'b0;

    // reset held with a valid command pending
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_cmd_ready", 128'(mem_if.mem_cmd_ready_and), 128'(0));
      check("rst_resp_v",    128'(mem_if.mem_resp_v),        128'(0));
    end
    check("rst_resp_last", 128'(mem_if.mem_resp_last),   128'(0));
    check("rst_resp_hdr",  128'(mem_if.mem_resp_header), 128'(0));
    check("rst_resp_data", 128'(mem_if.mem_resp_data),   128'(0));
    reset_i          = 1'b1;
    mem_if.mem_cmd_v = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 128'(mem_if.mem_cmd_ready_and), 128'(1));

    // fill the whole array so every later read has a defined expectation
    for (int b = 0; b < mem_els_lp / 8; b++) begin
      for (int i = 0; i < 8; i++) beat_data[i] = {$urandom(), $urandom()};
      do_write(make_hdr(e_bedrock_mem_wr, 40'(b * 64), 3'd6), 8, 1'b0);
    end

    // block write 0..7 at 0x80, then critical-word-first read at 0x90 with a 3-cycle stall on beat 4
    for (int i = 0; i < 8; i++) beat_data[i] = 64'(i);
    do_write(make_hdr(e_bedrock_mem_wr, 40'h80, 3'd6), 8, 1'b0);
    exp_data[0] = 64'd2; exp_data[1] = 64'd3; exp_data[2] = 64'd4; exp_data[3] = 64'd5;
    exp_data[4] = 64'd6; exp_data[5] = 64'd7; exp_data[6] = 64'd0; exp_data[7] = 64'd1;
    do_read(make_hdr(e_bedrock_mem_rd, 40'h90, 3'd6), 1'b0, 3, 3, 1'b0, -1);

    // sub-word byte write into a zeroed word
    beat_data[0] = 64'd0;
    do_write(make_hdr(e_bedrock_mem_uc_wr, 40'h80, 3'd3), 1, 1'b0);
    beat_data[0] = 64'hAB;
    do_write(make_hdr(e_bedrock_mem_uc_wr, 40'h83, 3'd0), 1, 1'b0);
    exp_data[0] = 64'h0000_0000_AB00_0000;
    do_read(make_hdr(e_bedrock_mem_uc_rd, 40'h80, 3'd3), 1'b0, -1, 0, 1'b0, -1);

    // upper address bits alias onto word 0
    beat_data[0] = 64'h5A;
    do_write(make_hdr(e_bedrock_mem_uc_wr, 40'h0, 3'd3), 1, 1'b0);
    exp_data[0] = 64'h5A;
    do_read(make_hdr(e_bedrock_mem_uc_rd, 40'(mem_els_lp * 8), 3'd3), 1'b0, -1, 0, 1'b0, -1);

    // reset after the second read beat is accepted, then a clean read
    h = make_hdr(e_bedrock_mem_rd, 40'h80, 3'd6);
    do_read(h, 1'b1, -1, 0, 1'b0, 2);
    @(negedge clk);
    mem_if.mem_resp_ready_and = 1'b0;
    reset_i = 1'b0;
    #1;
    check("midrst_resp_v",    128'(mem_if.mem_resp_v),        128'(0));
    check("midrst_cmd_ready", 128'(mem_if.mem_cmd_ready_and), 128'(0));
    repeat (2) begin
      @(negedge clk);
      check("midrst_hold_v", 128'(mem_if.mem_resp_v), 128'(0));
    end
    reset_i = 1'b1;
    mem_if.mem_resp_ready_and = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_beats", 128'(mem_if.mem_resp_v), 128'(0));
    end
    mem_if.mem_resp_ready_and = 1'b0;
    do_read(h, 1'b1, -1, 0, 1'b0, -1);

    // randomized traffic against the reference memory
    for (int it = 0; it < 60; it++) begin
      int sel;
      logic [2:0] sz;
      logic [39:0] a;
      bit rs;
      sel = $urandom_range(0, 5);
      sz  = 3'($urandom_range(0, 7));
      a   = {8'($urandom()), 32'($urandom())};
      if (sz < 3'd3) a[2:0] = 3'($urandom_range(0, 7)) & ~3'((32'd1 << sz) - 32'd1);
      else           a[2:0] = 3'd0;
      for (int i = 0; i < 8; i++) beat_data[i] = {$urandom(), $urandom()};
      rs = bit'($urandom_range(0, 1));
      case (sel)
        1:       do_write(make_hdr(e_bedrock_mem_wr,    a, sz), ref_beats(sz), rs);
        2:       do_read (make_hdr(e_bedrock_mem_uc_rd, a, sz), 1'b1, -1, 0, rs, -1);
        3:       do_write(make_hdr(e_bedrock_mem_uc_wr, a, sz), ref_beats(sz), rs);
        4:       do_write(make_hdr(e_bedrock_mem_pre,   a, sz), 1, rs);
        default: do_read (make_hdr(e_bedrock_mem_rd,    a, sz), 1'b1, -1, 0, rs, -1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
